// File: rtl/fw_pkg.sv
// rtl/fw_pkg.sv - shared constants and state encoding for the coefficient sequencer
package fw_pkg;

    localparam int FW_DEPTH  = 40;
    localparam int FW_COEF_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fw_state_e;

endpackage

// File: rtl/fw_coef_sequencer.sv
// rtl/fw_coef_sequencer.sv - walks the coefficient ROM num_pass times and streams it out
module fw_coef_sequencer
    import fw_pkg::*;
#(
    parameter int WIDTH_A = 12,
    parameter int DEPTH   = FW_DEPTH,
    parameter int COEF_W  = FW_COEF_W,
    parameter int PASS_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [PASS_W-1:0]  num_pass,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_A-1:0] rom_addr,
    input  logic [COEF_W-1:0]  rom_coef,
    output logic [COEF_W-1:0]  coef_out,
    output logic               coef_valid,
    input  logic               coef_ready,
    output logic               coef_last,
    output logic [PASS_W-1:0]  pass_idx
);

    localparam logic [WIDTH_A-1:0] LAST_ADDR = WIDTH_A'(DEPTH - 1);

    fw_state_e          state_q, state_d;
    logic [WIDTH_A-1:0] addr_q, addr_d;
    logic [PASS_W-1:0]  pass_q, pass_d;
    logic [PASS_W-1:0]  num_pass_q, num_pass_d;
    logic [COEF_W-1:0]  coef_out_q, coef_out_d;
    logic               coef_valid_q, coef_valid_d;
    logic               coef_last_q, coef_last_d;
    logic [PASS_W-1:0]  pass_idx_q, pass_idx_d;
    logic               done_q, done_d;
    logic               ld;

    // The output register reloads whenever it is empty or its beat is being taken.
    assign ld = !coef_valid_q || coef_ready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pass_d       = pass_q;
        num_pass_d   = num_pass_q;
        coef_out_d   = coef_out_q;
        coef_valid_d = coef_valid_q;
        coef_last_d  = coef_last_q;
        pass_idx_d   = pass_idx_q;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_pass != '0) begin
                        state_d    = ST_RUN;
                        addr_d     = '0;
                        pass_d     = '0;
                        num_pass_d = num_pass;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d      = ST_IDLE;
                    coef_valid_d = 1'b0;
                    coef_last_d  = 1'b0;
                    addr_d       = '0;
                    pass_d       = '0;
                end else if (ld) begin
                    coef_out_d   = rom_coef;
                    coef_valid_d = 1'b1;
                    coef_last_d  = (addr_q == LAST_ADDR);
                    pass_idx_d   = pass_q;
                    if (addr_q == LAST_ADDR) begin
                        addr_d = '0;
                        pass_d = pass_q + PASS_W'(1);
                        if (pass_q == num_pass_q - PASS_W'(1)) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        addr_d = addr_q + WIDTH_A'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d      = ST_IDLE;
                    coef_valid_d = 1'b0;
                    coef_last_d  = 1'b0;
                    addr_d       = '0;
                    pass_d       = '0;
                end else if (coef_valid_q && coef_ready) begin
                    state_d      = ST_IDLE;
                    coef_valid_d = 1'b0;
                    coef_last_d  = 1'b0;
                    done_d       = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                coef_valid_d = 1'b0;
                coef_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            pass_q       <= '0;
            num_pass_q   <= '0;
            coef_out_q   <= '0;
            coef_valid_q <= 1'b0;
            coef_last_q  <= 1'b0;
            pass_idx_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pass_q       <= pass_d;
            num_pass_q   <= num_pass_d;
            coef_out_q   <= coef_out_d;
            coef_valid_q <= coef_valid_d;
            coef_last_q  <= coef_last_d;
            pass_idx_q   <= pass_idx_d;
            done_q       <= done_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign rom_addr   = addr_q;
    assign coef_out   = coef_out_q;
    assign coef_valid = coef_valid_q;
    assign coef_last  = coef_last_q;
    assign pass_idx   = pass_idx_q;

endmodule

// File: tb/tb_fw_coef_sequencer.sv
// tb/tb_fw_coef_sequencer.sv - scoreboard bench for fw_coef_sequencer
module tb_fw_coef_sequencer;

    localparam int WIDTH_A = 12;
    localparam int DEPTH   = 40;
    localparam int COEF_W  = 3;
    localparam int PASS_W  = 8;

    typedef struct {
        logic [COEF_W-1:0] coef;
        logic              last;
        logic [PASS_W-1:0] pidx;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               coef_ready = 1'b0;
    logic [PASS_W-1:0]  num_pass = '0;
    logic               busy;
    logic               done;
    logic [WIDTH_A-1:0] rom_addr;
    logic [COEF_W-1:0]  rom_coef;
    logic [COEF_W-1:0]  coef_out;
    logic               coef_valid;
    logic               coef_last;
    logic [PASS_W-1:0]  pass_idx;

    logic [COEF_W-1:0]  rom [DEPTH];
    exp_t               exp_q[$];
    exp_t               mon_e;
    int                 vectors = 0;
    int                 miscompares = 0;
    int                 beats = 0;
    logic               prev_stall = 1'b0;
    logic [COEF_W-1:0]  held_coef;
    logic               held_last;
    logic [PASS_W-1:0]  held_pidx;

    fw_coef_sequencer #(
        .WIDTH_A(WIDTH_A), .DEPTH(DEPTH), .COEF_W(COEF_W), .PASS_W(PASS_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_pass(num_pass),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_coef(rom_coef),
        .coef_out(coef_out), .coef_valid(coef_valid), .coef_ready(coef_ready),
        .coef_last(coef_last), .pass_idx(pass_idx)
    );

    always #5 clk = ~clk;

    assign rom_coef = (rom_addr < WIDTH_A'(DEPTH)) ? rom[rom_addr] : '0;

    // One clock: scoreboard sampling at the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rst && !abort) begin
            if (prev_stall) begin
                vectors++;
                if (coef_valid !== 1'b1 || coef_out !== held_coef ||
                    coef_last !== held_last || pass_idx !== held_pidx) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%0b c=%0d l=%0b p=%0d expected v=1 c=%0d l=%0b p=%0d",
                             coef_valid, coef_out, coef_last, pass_idx, held_coef, held_last, held_pidx);
                end
            end
            if (coef_valid && coef_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: got c=%0d l=%0b p=%0d expected no beat",
                             coef_out, coef_last, pass_idx);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (coef_out !== mon_e.coef || coef_last !== mon_e.last || pass_idx !== mon_e.pidx) begin
                        miscompares++;
                        $display("FAIL beat_%0d: got c=%0d l=%0b p=%0d expected c=%0d l=%0b p=%0d",
                                 beats, coef_out, coef_last, pass_idx, mon_e.coef, mon_e.last, mon_e.pidx);
                    end
                end
                beats++;
            end
            prev_stall = coef_valid && !coef_ready;
            held_coef  = coef_out;
            held_last  = coef_last;
            held_pidx  = pass_idx;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n);
        exp_t e;
        exp_q.delete();
        beats = 0;
        for (int p = 0; p < n; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                e.coef = rom[a];
                e.last = (a == DEPTH - 1);
                e.pidx = PASS_W'(p);
                exp_q.push_back(e);
            end
        end
        num_pass = PASS_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: ready high; 1: ready toggles; 2: final beat stalled 5 cycles.
    task automatic wait_run(input int budget, input int mode, input int start_at,
                            output int done_k, output int first_k);
        int stall;
        stall = 0;
        done_k = -1;
        first_k = -1;
        for (int k = 1; k <= budget; k++) begin
            case (mode)
                1: coef_ready = (k % 2 == 1);
                2: begin
                    if (coef_valid && coef_last && stall < 5) begin
                        coef_ready = 1'b0;
                        stall++;
                    end else begin
                        coef_ready = 1'b1;
                    end
                end
                default: coef_ready = 1'b1;
            endcase
            start = (k == start_at);
            if (k == start_at) num_pass = 8'd5;
            tick();
            if (first_k < 0 && coef_valid) first_k = k;
            if (done) begin
                done_k = k;
                break;
            end
        end
        start = 1'b0;
        coef_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        vectors++;
        if ({busy, done, coef_valid, coef_last} !== 4'b0000 || coef_out !== '0 ||
            pass_idx !== '0 || rom_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got b=%0b d=%0b v=%0b l=%0b c=%0d p=%0d a=%0d expected all 0",
                     busy, done, coef_valid, coef_last, coef_out, pass_idx, rom_addr);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got busy=%0b expected 0", busy);
        end
    endtask

    task automatic test_single_pass();
        int dk, fk;
        start_run(1);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy: got %0b expected 1", busy);
        end
        wait_run(100, 0, -1, dk, fk);
        vectors++;
        if (fk !== 1) begin
            miscompares++;
            $display("FAIL single_first_valid: got k=%0d expected 1", fk);
        end
        vectors++;
        if (dk !== 41) begin
            miscompares++;
            $display("FAIL single_done_cycle: got k=%0d expected 41", dk);
        end
        vectors++;
        if (beats !== 40 || exp_q.size() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_count: got beats=%0d left=%0d busy=%0b expected 40 0 0",
                     beats, exp_q.size(), busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done_pulse: got %0b expected 0", done);
        end
    endtask

    task automatic test_ready_toggle();
        int dk, fk;
        start_run(1);
        wait_run(200, 1, -1, dk, fk);
        vectors++;
        if (dk < 0 || beats !== 40 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL toggle_run: got done_k=%0d beats=%0d left=%0d expected done beats=40 left=0",
                     dk, beats, exp_q.size());
        end
    endtask

    task automatic test_multi_pass();
        int dk, fk;
        start_run(3);
        wait_run(300, 0, -1, dk, fk);
        vectors++;
        if (dk !== 121 || beats !== 120 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL multi_run: got done_k=%0d beats=%0d left=%0d expected 121 120 0",
                     dk, beats, exp_q.size());
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL multi_single_done: got done=%0b busy=%0b expected 0 0", done, busy);
        end
    endtask

    task automatic test_zero_pass();
        start_run(0);
        vectors++;
        if ({done, busy, coef_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL zero_done: got d/b/v=%03b expected 100", {done, busy, coef_valid});
        end
        tick();
        vectors++;
        if ({done, busy, coef_valid} !== 3'b000 || beats !== 0) begin
            miscompares++;
            $display("FAIL zero_after: got d/b/v=%03b beats=%0d expected 000 0",
                     {done, busy, coef_valid}, beats);
        end
    endtask

    task automatic test_start_mid_run();
        int dk, fk;
        start_run(1);
        wait_run(100, 0, 20, dk, fk);
        vectors++;
        if (dk !== 41 || beats !== 40 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL start_ignored: got done_k=%0d beats=%0d left=%0d expected 41 40 0",
                     dk, beats, exp_q.size());
        end
    endtask

    task automatic test_abort();
        int dk, fk, n, seen_done;
        start_run(1);
        coef_ready = 1'b1;
        n = 0;
        while (beats < 10 && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if (beats < 10) begin
            miscompares++;
            $display("FAIL abort_reach: got beats=%0d expected 10", beats);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if ({busy, coef_valid, done} !== 3'b000 || rom_addr !== '0) begin
            miscompares++;
            $display("FAIL abort_idle: got b/v/d=%03b addr=%0d expected 000 0",
                     {busy, coef_valid, done}, rom_addr);
        end
        exp_q.delete();
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) seen_done++;
        end
        vectors++;
        if (seen_done !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", seen_done);
        end
        start_run(1);
        wait_run(100, 0, -1, dk, fk);
        vectors++;
        if (dk !== 41 || beats !== 40 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL abort_restart: got done_k=%0d beats=%0d left=%0d expected 41 40 0",
                     dk, beats, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_run();
        int dk, fk, n;
        start_run(2);
        coef_ready = 1'b1;
        n = 0;
        while (beats < 20 && n < 100) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({busy, done, coef_valid, coef_last} !== 4'b0000 || coef_out !== '0 ||
            pass_idx !== '0 || rom_addr !== '0 || beats < 20) begin
            miscompares++;
            $display("FAIL rst_mid_run: got b=%0b d=%0b v=%0b l=%0b c=%0d p=%0d a=%0d beats=%0d expected all 0 beats>=20",
                     busy, done, coef_valid, coef_last, coef_out, pass_idx, rom_addr, beats);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_done: got %0b expected 0", done);
        end
        start_run(1);
        wait_run(100, 0, -1, dk, fk);
        vectors++;
        if (dk !== 41 || beats !== 40 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL rst_restart: got done_k=%0d beats=%0d left=%0d expected 41 40 0",
                     dk, beats, exp_q.size());
        end
    endtask

    task automatic test_drain_stall();
        int dk, fk;
        start_run(1);
        wait_run(100, 2, -1, dk, fk);
        vectors++;
        if (dk !== 46 || beats !== 40 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL drain_stall: got done_k=%0d beats=%0d left=%0d expected 46 40 0",
                     dk, beats, exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = COEF_W'((i * 5 + 3) % 8);
        rom[0] = 3'd7; rom[1] = 3'd2; rom[2] = 3'd6; rom[3] = 3'd4; rom[4] = 3'd0;
        rom[38] = 3'd6; rom[39] = 3'd4;
        test_reset();
        test_single_pass();
        test_ready_toggle();
        test_multi_pass();
        test_zero_pass();
        test_start_mid_run();
        test_abort();
        test_reset_mid_run();
        test_drain_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
